// File: rtl/pwm_bank_pkg.sv
// ---------------------------------------------------------------------------
// pwm_bank_pkg
// Shared constants and helpers for the pwm_bank PWM generator:
//   - register map addresses (7-bit SPI register address space)
//   - reset values
//   - counter direction type (used only when PWM_CENTER_ALIGN_EN is defined)
//   - pwm_level(): the per-channel compare rule
// ---------------------------------------------------------------------------
package pwm_bank_pkg;

  localparam int MAX_CH = 32;

  // Register map
  localparam logic [6:0] ADDR_EN_OUT    = 7'h00;  // 0x00..0x03, one byte per 8 channels
  localparam logic [6:0] ADDR_EN_PWM    = 7'h04;  // 0x04..0x07
  localparam logic [6:0] ADDR_PRESC     = 7'h08;
  localparam logic [6:0] ADDR_TOP       = 7'h09;
  localparam logic [6:0] ADDR_CTRL      = 7'h0A;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;  // 0x10+i = DUTY[i]

  // Reset values
  localparam logic [7:0] TOP_RST = 8'hFF;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Duty 0xFF forces the output high regardless of TOP; otherwise the
  // output is high while the counter is below the duty value.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == 8'hFF) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// ---------------------------------------------------------------------------
// pwm_bank_if
// Register-write bus from the SPI peripheral into pwm_bank. No back-pressure:
// every wr_en strobe is accepted.
//   wr_en    1  one-cycle write strobe
//   wr_addr  7  register address
//   wr_data  8  write data
// Modports: master (SPI side, drives), slave (pwm_bank, receives).
// ---------------------------------------------------------------------------
interface pwm_bank_if;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_bank_timebase.sv
// ---------------------------------------------------------------------------
// pwm_timebase
// Shared time base for all PWM channels: prescaler, period counter, period
// boundary detection and the period_start pulse.
// Optional feature: `define PWM_CENTER_ALIGN_EN adds up/down counting,
// selected per period by center_req (sampled at each boundary).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   presc          prescaler terminal value (tick every presc+1 clocks)
//   presc_restart  restart the prescaler at 0 (PRESC register write)
//   top_act        active TOP value
//   center_req     (PWM_CENTER_ALIGN_EN only) requested center-aligned mode
//   cnt            period counter
//   boundary       combinational: this edge ends the period, load shadows
//   period_start   registered: high on the first cycle of cnt == 0
// ---------------------------------------------------------------------------
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] presc,
  input  logic               presc_restart,
  input  logic [7:0]         top_act,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic               center_req,
`endif
  output logic [7:0]         cnt,
  output logic               boundary,
  output logic               period_start
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic               at_end;

  assign tick = (presc_cnt == presc);

`ifdef PWM_CENTER_ALIGN_EN
  dir_e dir;
  logic center_act;  // mode in force for the current period

  always_comb begin
    // NOTE: give every always_comb output a default before any branch so no path infers a latch.
    at_end = (cnt == top_act);
    // In center mode the period ends stepping down from 1 to 0; a TOP of 0
    // degenerates to a one-tick period as in edge mode.
    if (center_act) at_end = (top_act == 8'd0) || ((dir == DIR_DOWN) && (cnt == 8'd1));
  end
`else
  assign at_end = (cnt == top_act);
`endif

  assign boundary = tick && at_end;

  // Prescaler
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      presc_cnt <= '0;
    end else if (presc_restart || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Period counter and period_start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= 8'd0;
      period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir          <= DIR_UP;
      center_act   <= 1'b0;
`endif
    end else begin
      period_start <= boundary;
      if (boundary) begin
        cnt <= 8'd0;
`ifdef PWM_CENTER_ALIGN_EN
        dir        <= DIR_UP;
        center_act <= center_req;
`endif
      end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
        if (center_act && (dir == DIR_UP) && (cnt == top_act)) begin
          dir <= DIR_DOWN;
          cnt <= cnt - 1'b1;
        end else if (center_act && (dir == DIR_DOWN)) begin
          cnt <= cnt - 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
`else
        cnt <= cnt + 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// ---------------------------------------------------------------------------
// pwm_bank
// Multi-channel PWM generator sharing one time base. Holds the register file
// (enables, prescaler, TOP/DUTY shadow + active copies) and the per-channel
// compare and output mux. TOP and DUTY writes land in shadows and become
// active only at a period boundary, so a period never glitches.
// Optional feature: `define PWM_CENTER_ALIGN_EN enables CTRL[0] center-aligned
// counting; without it CTRL writes have no effect.
// Parameters: NUM_CH (1..32 channels), PRESC_W (prescaler width).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   bus            pwm_bank_if.slave register-write bus
//   out            registered channel outputs
//   period_start   one-cycle pulse on the first cycle of each period
// ---------------------------------------------------------------------------
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_bank_if.slave         bus,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("pwm_bank: NUM_CH must be within 1..32");
  end

  logic [NUM_CH-1:0]  en_out, en_out_nxt;
  logic [NUM_CH-1:0]  en_pwm, en_pwm_nxt;
  logic [7:0]         duty_sh     [NUM_CH];
  logic [7:0]         duty_sh_nxt [NUM_CH];
  logic [7:0]         duty_act    [NUM_CH];
  logic [7:0]         top_sh, top_sh_nxt, top_act;
  logic [PRESC_W-1:0] presc;
  logic               presc_wr;
  logic               top_wr;
  logic [7:0]         cnt;
  logic               boundary;
  logic [NUM_CH-1:0]  pwm;

  assign presc_wr = bus.wr_en && (bus.wr_addr == ADDR_PRESC);
  assign top_wr   = bus.wr_en && (bus.wr_addr == ADDR_TOP);

  // Next-state of the write-side registers. The shadow next values also feed
  // the active copies, so a write landing on the boundary edge wins.
  always_comb begin
    en_out_nxt  = en_out;
    en_pwm_nxt  = en_pwm;
    duty_sh_nxt = duty_sh;
    top_sh_nxt  = top_wr ? bus.wr_data : top_sh;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.wr_en && (bus.wr_addr == ADDR_EN_OUT + 7'(i / 8)))
        en_out_nxt[i] = bus.wr_data[3'(i % 8)];
      if (bus.wr_en && (bus.wr_addr == ADDR_EN_PWM + 7'(i / 8)))
        en_pwm_nxt[i] = bus.wr_data[3'(i % 8)];
      if (bus.wr_en && (bus.wr_addr == ADDR_DUTY_BASE + 7'(i)))
        duty_sh_nxt[i] = bus.wr_data;
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_out  <= '0;
      en_pwm  <= '0;
      presc   <= '0;
      top_sh  <= TOP_RST;
      top_act <= TOP_RST;
      // NOTE: the duty arrays are reset explicitly; they are flops, not RAM, and must read 0 after reset.
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= 8'd0;
        duty_act[i] <= 8'd0;
      end
    end else begin
      en_out  <= en_out_nxt;
      en_pwm  <= en_pwm_nxt;
      top_sh  <= top_sh_nxt;
      duty_sh <= duty_sh_nxt;
      if (presc_wr) presc <= PRESC_W'(bus.wr_data);
      if (boundary) begin
        top_act  <= top_sh_nxt;
        duty_act <= duty_sh_nxt;
      end
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  logic center_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      center_req <= 1'b0;
    end else if (bus.wr_en && (bus.wr_addr == ADDR_CTRL)) begin
      center_req <= bus.wr_data[0];
    end
  end
`endif

  pwm_timebase #(
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .presc         (presc),
    .presc_restart (presc_wr),
    .top_act       (top_act),
`ifdef PWM_CENTER_ALIGN_EN
    .center_req    (center_req),
`endif
    .cnt           (cnt),
    .boundary      (boundary),
    .period_start  (period_start)
  );

  // Per-channel compare
  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_CH; i++) pwm[i] = pwm_level(cnt, duty_act[i]);
  end

  // Output stage: disabled -> 0, static -> 1, otherwise the compare result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= en_out & (~en_pwm | pwm);
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_bank
// Directed bench for pwm_bank (default build, edge-aligned). Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_bank;
  import pwm_bank_pkg::*;

  localparam int NUM_CH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  int n_vec = 0;
  int n_err = 0;

  pwm_bank_if bus ();

  pwm_bank #(
    .NUM_CH  (NUM_CH),
    .PRESC_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Returns at the falling edge of a cycle with period_start high.
  task automatic wait_ps(input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the first cycle of a period (k = 0). Samples out[ch] for each
  // cycle of the period and returns at the first cycle of the next one.
  // len = 0 means no next period_start within budget. edges counts output
  // changes between cycles k = 1 .. len-1. Optionally issues one register
  // write driven during cycle k = wr_at.
  task automatic measure(input int ch, input int budget, input int wr_at,
                         input logic [6:0] wa, input logic [7:0] wd,
                         output int len, output int highs, output int edges);
    logic prev;
    len   = 0;
    highs = 0;
    edges = 0;
    prev  = 1'b0;
    if (out[ch[3:0]]) highs++;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (period_start) begin
        len = c;
        break;
      end
      if (out[ch[3:0]]) highs++;
      if (c >= 2 && out[ch[3:0]] !== prev) edges++;
      prev = out[ch[3:0]];
      if (c == wr_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wd;
      end
    end
  endtask

  initial begin
    logic ok;
    int   len, highs, edges, ps_seen;

    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 7'd0;
    bus.wr_data = 8'd0;

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_period_start", 32'(period_start), 32'h0);
    check("rst_cnt", 32'(dut.u_timebase.cnt), 32'h0);
    rst_n = 1'b1;

    // Idle after reset: nothing enabled, no period end within 20 clocks
    ps_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (period_start) ps_seen++;
    end
    check("idle_period_start_count", 32'(ps_seen), 32'd0);
    check("idle_out", 32'(out), 32'h0);

    // Static enable on channel 0: register updates on the write edge, out one edge later
    wr(ADDR_EN_OUT, 8'h01);
    check("en_out_before_latency", 32'(out), 32'h0);
    @(negedge clk);
    check("en_out_static_high", 32'(out), 32'h0001);

    // PWM on channel 0 with DUTY 0x40: shadow only until the first boundary
    wr(ADDR_DUTY_BASE, 8'h40);
    wr(ADDR_EN_PWM, 8'h01);
    @(negedge clk);
    check("duty_shadow_not_active", 32'(out), 32'h0);

    wait_ps(600, ok);
    check("wait_first_boundary", 32'(ok), 32'd1);

    // Period 1: 64 high out of 256
    measure(0, 300, -1, 7'd0, 8'd0, len, highs, edges);
    check("p1_len", 32'(len), 32'd256);
    check("p1_high", 32'(highs), 32'd64);
    check("p1_edges", 32'(edges), 32'd1);

    // Period 2: DUTY 0xC0 written mid-period, current period unaffected
    measure(0, 300, 100, ADDR_DUTY_BASE, 8'hC0, len, highs, edges);
    check("p2_len", 32'(len), 32'd256);
    check("p2_high", 32'(highs), 32'd64);
    check("p2_edges", 32'(edges), 32'd1);

    // Period 3: 192 high; DUTY 0x20 written on the boundary edge itself
    measure(0, 300, 255, ADDR_DUTY_BASE, 8'h20, len, highs, edges);
    check("p3_len", 32'(len), 32'd256);
    check("p3_high", 32'(highs), 32'd192);
    check("p3_edges", 32'(edges), 32'd1);

    // Period 4: boundary-edge write took effect
    measure(0, 300, -1, 7'd0, 8'd0, len, highs, edges);
    check("p4_len", 32'(len), 32'd256);
    check("p4_high", 32'(highs), 32'd32);

    // PRESC=3, TOP=9: ch0 DUTY 0xFF constant high, ch1 DUTY 0 constant low
    wr(ADDR_TOP, 8'd9);
    wr(ADDR_DUTY_BASE, 8'hFF);
    wr(ADDR_DUTY_BASE + 7'd1, 8'h00);
    wr(ADDR_EN_OUT, 8'h03);
    wr(ADDR_EN_PWM, 8'h03);
    wr(ADDR_PRESC, 8'd3);
    wait_ps(1200, ok);
    check("wait_top9_boundary", 32'(ok), 32'd1);
    measure(1, 100, -1, 7'd0, 8'd0, len, highs, edges);
    check("q1_len", 32'(len), 32'd40);
    check("q1_ch1_high", 32'(highs), 32'd0);
    measure(0, 100, -1, 7'd0, 8'd0, len, highs, edges);
    check("q2_len", 32'(len), 32'd40);
    check("q2_ch0_high", 32'(highs), 32'd40);

    // TOP=0, PRESC=1: cnt stays 0, period_start every tick (2 clocks)
    wr(ADDR_TOP, 8'd0);
    wr(ADDR_PRESC, 8'd1);
    wait_ps(100, ok);
    check("wait_top0_boundary", 32'(ok), 32'd1);
    measure(0, 20, -1, 7'd0, 8'd0, len, highs, edges);
    measure(0, 20, -1, 7'd0, 8'd0, len, highs, edges);
    check("t0_len", 32'(len), 32'd2);
    check("t0_ch0_high", 32'(highs), 32'd2);
    check("t0_cnt", 32'(dut.u_timebase.cnt), 32'd0);
    check("t0_out", 32'(out), 32'h0001);

    // Reset mid-operation with a pending shadow write
    wr(ADDR_DUTY_BASE, 8'h10);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_period_start", 32'(period_start), 32'h0);
    check("mid_rst_cnt", 32'(dut.u_timebase.cnt), 32'h0);
    check("mid_rst_top_act", 32'(dut.top_act), 32'hFF);
    check("mid_rst_duty_act0", 32'(dut.duty_act[0]), 32'h0);
    check("mid_rst_duty_sh0", 32'(dut.duty_sh[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_out", 32'(out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
